// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory address and registers {pc, instr, pc+4} into the IF/ID register with a
// valid/ready handshake, redirect/flush support and a sticky fetch-fault trap.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        pc_bad;
  logic        redirect_bad;

  // Misaligned or beyond the end of instruction memory.
  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= IMEM_WORDS);
  endfunction

  assign instr_addr   = pc;
  assign pc_plus4     = pc + 32'd4;
  assign advance      = !id_valid || id_ready;
  assign pc_bad       = bad_addr(pc);
  assign redirect_bad = bad_addr(redirect_pc);

  // Fetch FSM: boot delay, prioritised redirect / trap / advance, absorbing fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_instr    <= NOP;
      id_pc_plus4 <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            id_valid <= 1'b0;
            if (redirect_bad) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end else begin
              pc <= redirect_pc;
            end
          end else if (pc_bad) begin
            state       <= FAULT;
            id_valid    <= 1'b0;
            fetch_fault <= 1'b1;
          end else if (advance) begin
            id_pc       <= pc;
            id_instr    <= instr;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
            pc          <= pc_plus4;
          end
        end
        FAULT: begin
          id_valid    <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
